// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM/WB latch inputs, mult/div retire path,
// register-file write port and retire counter readout.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [31:0]      mw_o;
  logic [31:0]      mw_d;
  logic [31:0]      mw_ir;
  logic             mw_ovf;
  logic             md_valid;
  logic [31:0]      md_result;
  logic             md_ovf;
  logic             md_op;
  logic [4:0]       md_rd;
  logic             md_ready;
  logic             wr_en;
  logic [4:0]       wr_reg;
  logic [31:0]      wr_data;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output en, mw_o, mw_d, mw_ir, mw_ovf,
    output md_valid, md_result, md_ovf, md_op, md_rd,
    input  md_ready, wr_en, wr_reg, wr_data, retire_count
  );

  modport slave (
    input  en, mw_o, mw_d, mw_ir, mw_ovf,
    input  md_valid, md_result, md_ovf, md_op, md_rd,
    output md_ready, wr_en, wr_reg, wr_data, retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: decodes the MEM/WB latch into a register-file write,
// arbitrates the single write port against mult/div results through a
// one-entry holding buffer, and counts retired instructions.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      clr,
  wb_stage_if.slave bus
);

  logic [4:0]       op, rd, aluop;
  logic             pc_v;
  logic [4:0]       pc_reg;
  logic [31:0]      pc_data;

  logic             md_acc, md_live;
  logic [4:0]       md_reg;
  logic [31:0]      md_data;

  logic             buf_v, buf_nv;
  logic [4:0]       buf_reg, buf_nreg;
  logic [31:0]      buf_data, buf_ndata;

  logic             sel_v;
  logic [4:0]       sel_reg;
  logic [31:0]      sel_data;
  logic             md_wr, pipe_ret;

  logic             wr_en_q;
  logic [4:0]       wr_reg_q;
  logic [31:0]      wr_data_q;
  logic [CNT_W-1:0] cnt_q;

  assign op    = bus.mw_ir[31:27];
  assign rd    = bus.mw_ir[26:22];
  assign aluop = bus.mw_ir[6:2];

  // Pipeline write candidate; exceptions redirect the write to r30.
  always_comb begin
    pc_v    = 1'b0;
    pc_reg  = rd;
    pc_data = bus.mw_o;
    if (bus.en) begin
      case (op)
        5'b00000: begin
          if (aluop != 5'b00110 && aluop != 5'b00111) begin
            pc_v = 1'b1;
            if (bus.mw_ovf && aluop == 5'b00000) begin
              pc_reg  = 5'd30;
              pc_data = 32'd1;
            end else if (bus.mw_ovf && aluop == 5'b00001) begin
              pc_reg  = 5'd30;
              pc_data = 32'd3;
            end
          end
        end
        5'b00101: begin
          pc_v = 1'b1;
          if (bus.mw_ovf) begin
            pc_reg  = 5'd30;
            pc_data = 32'd2;
          end
        end
        5'b01000: begin
          pc_v    = 1'b1;
          pc_data = bus.mw_d;
        end
        5'b00011: begin
          pc_v   = 1'b1;
          pc_reg = 5'd31;
        end
        5'b10101: begin
          pc_v    = 1'b1;
          pc_reg  = 5'd30;
          pc_data = {5'b0, bus.mw_ir[26:0]};
        end
        default: pc_v = 1'b0;
      endcase
    end
    if (pc_reg == 5'd0) pc_v = 1'b0;
  end

  // Incoming mult/div entry; ignored while the buffer is occupied.
  always_comb begin
    md_acc  = bus.md_valid && !buf_v;
    md_reg  = bus.md_ovf ? 5'd30 : bus.md_rd;
    md_data = bus.md_ovf ? (bus.md_op ? 32'd5 : 32'd4) : bus.md_result;
    md_live = md_acc && (md_reg != 5'd0);
  end

  // Port arbitration: pipeline, then buffer, then incoming md entry.
  always_comb begin
    sel_v     = 1'b0;
    sel_reg   = 5'd0;
    sel_data  = 32'd0;
    md_wr     = 1'b0;
    buf_nv    = buf_v;
    buf_nreg  = buf_reg;
    buf_ndata = buf_data;
    if (pc_v) begin
      sel_v    = 1'b1;
      sel_reg  = pc_reg;
      sel_data = pc_data;
      // the younger pipeline write to the same register makes an md entry dead
      if (buf_v && buf_reg == pc_reg) buf_nv = 1'b0;
      if (md_live && md_reg != pc_reg) begin
        buf_nv    = 1'b1;
        buf_nreg  = md_reg;
        buf_ndata = md_data;
      end
    end else if (buf_v) begin
      sel_v    = 1'b1;
      sel_reg  = buf_reg;
      sel_data = buf_data;
      md_wr    = 1'b1;
      buf_nv   = 1'b0;
    end else if (md_live) begin
      sel_v    = 1'b1;
      sel_reg  = md_reg;
      sel_data = md_data;
      md_wr    = 1'b1;
    end
  end

  assign pipe_ret = bus.en && (bus.mw_ir != 32'd0);

  // Registered write port, holding buffer and retire counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
      buf_v     <= 1'b0;
      buf_reg   <= 5'd0;
      buf_data  <= 32'd0;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= sel_v;
      wr_reg_q  <= sel_reg;
      wr_data_q <= sel_data;
      buf_v     <= buf_nv;
      buf_reg   <= buf_nreg;
      buf_data  <= buf_ndata;
      cnt_q     <= cnt_q + CNT_W'(pipe_ret) + CNT_W'(md_wr);
    end
  end

  assign bus.md_ready     = !buf_v;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_reg       = wr_reg_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_wb_stage;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(CNT_W)) bus ();
  wb_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] d;
  } ent_t;

  ent_t             m_q[$];
  logic             exp_en   = 1'b0;
  logic [4:0]       exp_reg  = 5'd0;
  logic [31:0]      exp_data = 32'd0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register-file effect of one retiring instruction, straight from the ISA rules.
  function automatic bit pipe_write(input logic [31:0] ir, input logic [31:0] o,
                                    input logic [31:0] d, input logic ovf,
                                    output logic [4:0] rg, output logic [31:0] val);
    logic [4:0] opc, alu;
    opc = ir[31:27];
    alu = ir[6:2];
    rg  = ir[26:22];
    val = o;
    if (opc == 5'd0) begin
      if (alu == 5'd6 || alu == 5'd7) return 1'b0;
      if (ovf && alu == 5'd0) begin rg = 5'd30; val = 32'd1; end
      else if (ovf && alu == 5'd1) begin rg = 5'd30; val = 32'd3; end
    end else if (opc == 5'd5) begin
      if (ovf) begin rg = 5'd30; val = 32'd2; end
    end else if (opc == 5'd8) begin
      val = d;
    end else if (opc == 5'd3) begin
      rg = 5'd31;
    end else if (opc == 5'd21) begin
      rg  = 5'd30;
      val = {5'b0, ir[26:0]};
    end else begin
      return 1'b0;
    end
    return rg != 5'd0;
  endfunction

  // Reference model: what the port must show after each edge.
  always @(posedge clk) begin : mdl
    bit          pv, acc;
    logic [4:0]  pr;
    logic [31:0] pd;
    ent_t        e, h;
    if (clr) begin
      m_q.delete();
      exp_en   = 1'b0;
      exp_reg  = 5'd0;
      exp_data = 32'd0;
      exp_cnt  = '0;
    end else begin
      pv  = pipe_write(bus.mw_ir, bus.mw_o, bus.mw_d, bus.mw_ovf, pr, pd);
      pv  = pv && bus.en;
      acc = 1'b0;
      e   = '0;
      if (bus.md_valid && m_q.size() == 0) begin
        e.rg = bus.md_ovf ? 5'd30 : bus.md_rd;
        e.d  = bus.md_ovf ? (bus.md_op ? 32'd5 : 32'd4) : bus.md_result;
        acc  = (e.rg != 5'd0);
      end
      exp_en = 1'b0;
      if (pv) begin
        exp_en = 1'b1; exp_reg = pr; exp_data = pd;
        for (int i = m_q.size() - 1; i >= 0; i--)
          if (m_q[i].rg == pr) m_q.delete(i);
        if (acc && e.rg != pr) m_q.push_back(e);
      end else if (m_q.size() > 0) begin
        h = m_q.pop_front();
        exp_en = 1'b1; exp_reg = h.rg; exp_data = h.d;
        exp_cnt = exp_cnt + 1'b1;
      end else if (acc) begin
        exp_en = 1'b1; exp_reg = e.rg; exp_data = e.d;
        exp_cnt = exp_cnt + 1'b1;
      end
      if (bus.en && bus.mw_ir != 32'd0) exp_cnt = exp_cnt + 1'b1;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_wr_en", 32'(bus.wr_en), 32'(exp_en));
      if (exp_en) begin
        chk("m_wr_reg", 32'(bus.wr_reg), 32'(exp_reg));
        chk("m_wr_data", bus.wr_data, exp_data);
      end
      chk("m_md_ready", 32'(bus.md_ready), 32'(m_q.size() == 0));
      chk("m_retire_count", 32'(bus.retire_count), 32'(exp_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] ir, input logic [31:0] o,
                       input logic [31:0] d, input logic ovf, input logic mdv,
                       input logic [4:0] mdr, input logic [31:0] mdres,
                       input logic mdovf, input logic mdop);
    bus.en = en; bus.mw_ir = ir; bus.mw_o = o; bus.mw_d = d; bus.mw_ovf = ovf;
    bus.md_valid = mdv; bus.md_rd = mdr; bus.md_result = mdres;
    bus.md_ovf = mdovf; bus.md_op = mdop;
  endtask

  task automatic pipe(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                      input logic ovf);
    drive(1'b1, ir, o, d, ovf, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_wr(input string nm, input logic en, input logic [4:0] r,
                           input logic [31:0] d, input int cnt);
    chk({nm, "_wr_en"}, 32'(bus.wr_en), 32'(en));
    if (en) begin
      chk({nm, "_wr_reg"}, 32'(bus.wr_reg), 32'(r));
      chk({nm, "_wr_data"}, bus.wr_data, d);
    end
    chk({nm, "_count"}, 32'(bus.retire_count), 32'(cnt));
  endtask

  function automatic logic [31:0] i_ins(input logic [4:0] opc, input logic [4:0] r);
    return {opc, r, 22'd0};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] r, input logic [4:0] alu);
    return {5'd0, r, 15'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [4:0]  opc, r, alu;
    logic [31:0] x;
    x = $urandom();
    r = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) r = 5'($urandom_range(28, 31));
    case ($urandom_range(0, 7))
      0: opc = 5'd0;
      1: opc = 5'd5;
      2: opc = 5'd8;
      3: opc = 5'd3;
      4: opc = 5'd21;
      5: opc = 5'd7;
      6: opc = 5'd0;
      default: opc = 5'($urandom());
    endcase
    case ($urandom_range(0, 4))
      0: alu = 5'd0;
      1: alu = 5'd1;
      2: alu = 5'd6;
      3: alu = 5'd7;
      default: alu = 5'($urandom());
    endcase
    if ($urandom_range(0, 15) == 0) return 32'd0;
    return {opc, r, x[21:7], alu, x[1:0]};
  endfunction

  initial begin
    idle();
    clr = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_reg", 32'(bus.wr_reg), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
    chk("rst_count", 32'(bus.retire_count), 32'd0);
    clr = 1'b0;
    chk_on = 1'b1;

    pipe(i_ins(5'd5, 5'd5), 32'h10, 32'd0, 1'b0);             tick(); expect_wr("addi", 1, 5'd5, 32'h10, 1);
    pipe(i_ins(5'd5, 5'd5), 32'h10, 32'd0, 1'b1);             tick(); expect_wr("addi_ovf", 1, 5'd30, 32'd2, 2);
    pipe(r_ins(5'd3, 5'd1), 32'h77, 32'd0, 1'b1);             tick(); expect_wr("sub_ovf", 1, 5'd30, 32'd3, 3);
    pipe(i_ins(5'd8, 5'd7), 32'h5, 32'hDEAD, 1'b0);           tick(); expect_wr("lw", 1, 5'd7, 32'hDEAD, 4);
    pipe({5'b10101, 27'h123}, 32'h9, 32'd0, 1'b0);            tick(); expect_wr("setx", 1, 5'd30, 32'h123, 5);
    pipe(i_ins(5'd3, 5'd0), 32'h40, 32'd0, 1'b0);             tick(); expect_wr("jal", 1, 5'd31, 32'h40, 6);
    pipe(i_ins(5'd5, 5'd0), 32'h55, 32'd0, 1'b0);             tick(); expect_wr("addi_r0", 0, 5'd0, 32'd0, 7);
    pipe(i_ins(5'd7, 5'd4), 32'h55, 32'd0, 1'b0);             tick(); expect_wr("sw", 0, 5'd0, 32'd0, 8);

    drive(1'b1, i_ins(5'd5, 5'd5), 32'd1, 32'd0, 1'b0, 1'b1, 5'd9, 32'd42, 1'b0, 1'b0);
    tick(); expect_wr("coll_pipe", 1, 5'd5, 32'd1, 9);
    chk("coll_ready_lo", 32'(bus.md_ready), 32'd0);
    idle(); tick(); expect_wr("coll_md", 1, 5'd9, 32'd42, 10);
    chk("coll_ready_hi", 32'(bus.md_ready), 32'd1);

    drive(1'b1, i_ins(5'd5, 5'd5), 32'd7, 32'd0, 1'b0, 1'b1, 5'd5, 32'd99, 1'b0, 1'b0);
    tick(); expect_wr("same_reg", 1, 5'd5, 32'd7, 11);
    chk("same_reg_ready", 32'(bus.md_ready), 32'd1);
    idle(); tick(); expect_wr("same_reg_after", 0, 5'd0, 32'd0, 11);

    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd12, 32'h1234, 1'b1, 1'b1);
    tick(); expect_wr("div_ovf", 1, 5'd30, 32'd5, 12);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd12, 32'h1234, 1'b1, 1'b0);
    tick(); expect_wr("mul_ovf", 1, 5'd30, 32'd4, 13);
    pipe(i_ins(5'd7, 5'd1), 32'd0, 32'd0, 1'b0); tick();
    pipe(i_ins(5'd7, 5'd1), 32'd0, 32'd0, 1'b0); tick(); expect_wr("cnt_max", 0, 5'd0, 32'd0, 15);
    pipe(i_ins(5'd7, 5'd1), 32'd0, 32'd0, 1'b0); tick(); expect_wr("cnt_wrap", 0, 5'd0, 32'd0, 0);

    drive(1'b1, i_ins(5'd5, 5'd5), 32'd1, 32'd0, 1'b0, 1'b1, 5'd9, 32'd42, 1'b0, 1'b0);
    tick(); chk("pre_rst_ready", 32'(bus.md_ready), 32'd0);
    clr = 1'b1;
    pipe(i_ins(5'd5, 5'd6), 32'd3, 32'd0, 1'b0);
    tick();
    chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("mid_rst_wr_reg", 32'(bus.wr_reg), 32'd0);
    chk("mid_rst_wr_data", bus.wr_data, 32'd0);
    chk("mid_rst_ready", 32'(bus.md_ready), 32'd1);
    chk("mid_rst_count", 32'(bus.retire_count), 32'd0);
    tick();
    clr = 1'b0;
    idle();
    tick(); expect_wr("post_rst", 0, 5'd0, 32'd0, 0);

    for (int c = 0; c < 4000; c++) begin
      logic mdv;
      mdv = ($urandom_range(0, 9) < 4);
      if (!bus.md_ready && $urandom_range(0, 9) != 0) mdv = 1'b0;
      drive(($urandom_range(0, 3) != 0), rand_ir(), $urandom(), $urandom(),
            ($urandom_range(0, 3) == 0), mdv,
            ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom()),
            $urandom(), ($urandom_range(0, 7) == 0), 1'($urandom()));
      clr = ($urandom_range(0, 249) == 0);
      tick();
    end
    clr = 1'b0;
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage processor: consumes the MEM/WB pipeline latch outputs (O, D, IR, overflow), decodes the instruction, and drives the register-file write port. Also retires results from the multi-cycle mult/div unit through a one-entry holding buffer, arbitrating the single write port with the pipeline. Maintains a retired-instruction counter for debug and performance readout.

## Interface
- CNT_W, 32, width of retire counter
- clk  in  1  processor clock
- clr  in  1  synchronous active-high reset
- en  in  1  pipeline advance; MEM/WB latch contents valid this cycle when 1
- mw_o  in  32  ALU result / PC+1 from MEM/WB latch
- mw_d  in  32  load data from MEM/WB latch
- mw_ir  in  32  instruction from MEM/WB latch
- mw_ovf  in  1  ALU overflow from MEM/WB latch
- md_valid  in  1  mult/div result valid
- md_result  in  32  mult/div result
- md_ovf  in  1  mult/div exception
- md_op  in  1  0 = mul, 1 = div
- md_rd  in  5  mult/div destination register
- md_ready  out  1  holding buffer can accept (= !buf_valid)
- wr_en  out  1  register-file write enable
- wr_reg  out  5  register-file write address
- wr_data  out  32  register-file write data
- retire_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

## Operation
- Decode: op = mw_ir[31:27], rd = mw_ir[26:22], aluop = mw_ir[6:2].
- Pipeline write candidate (only when en=1):
  - op 00000, aluop not 00110/00111: rd <= mw_o; if mw_ovf and aluop 00000 (add): r30 <= 1; aluop 00001 (sub): r30 <= 3.
  - op 00101 (addi): rd <= mw_o; if mw_ovf: r30 <= 2.
  - op 01000 (lw): rd <= mw_d.
  - op 00011 (jal): r31 <= mw_o.
  - op 10101 (setx): r30 <= {5'b0, mw_ir[26:0]}.
  - All other ops, and R-type mul/div (aluop 00110/00111; written via md path): no write.
  - Candidate with target r0: suppressed.
- Mult/div entry: md_ovf=1 -> r30 <= 4 (mul) or 5 (div); else md_rd <= md_result. Entry with target r0 is dropped on acceptance.
- Buffer: one entry {valid, reg, data}. md_valid with md_ready=0 is a protocol violation; the input is ignored.
- Port priority each cycle: (1) pipeline candidate, (2) buffered md entry, (3) incoming md entry.
  - Pipeline wins and md entry incoming: entry loaded into buffer.
  - Buffer is written when the pipeline has no candidate; buffer clears the same cycle.
  - No pipeline candidate, buffer empty, md_valid: md entry written directly, buffer untouched.
- Same-register conflict: a buffered or incoming md entry whose target equals the pipeline candidate's target in the same cycle is discarded. The pipeline instruction is younger; the hazard unit guarantees this ordering.
- retire_count: +1 when en=1 and mw_ir != 0; +1 when an md entry is written to the port. Both may occur in one cycle (+2). Discarded md entries do not count.
- en=0: pipeline inputs ignored entirely; md path, buffer and port continue operating.

## Timing
- wr_en/wr_reg/wr_data are registered: the selection made in cycle N appears in cycle N+1 for the register-file edge at the end of N+1.
- md_ready is combinational from buf_valid: deasserts the cycle after a buffer load, reasserts the cycle after the buffer drains.
- Worst-case md latency: 1 cycle direct, 2+ cycles when buffered behind consecutive pipeline writes.
- Reset (clr=1 at edge): wr_en=0, wr_reg=0, wr_data=0, buf_valid=0 (md_ready=1), retire_count=0. A buffered entry is lost. Inputs in the reset cycle are ignored.

## Test plan
- Reset: assert clr 2 cycles mid-traffic with buffer full -> wr_en=0, wr_reg=0, wr_data=0, md_ready=1, retire_count=0 the next cycle.
- ALU/exception: addi r5, mw_o=0x10, mw_ovf=0 -> wr_en=1, wr_reg=5, wr_data=0x10. Same with mw_ovf=1 -> wr_reg=30, wr_data=2. Sub with ovf -> r30=3.
- Other writers: lw r7 with mw_d=0xDEAD -> r7=0xDEAD. setx T=0x123 -> r30=0x123. jal with mw_o=0x40 -> r31=0x40. addi r0 -> wr_en=0. sw -> wr_en=0, retire_count +1.
- Collision: cycle 1 addi r5 (o=1) plus md_valid rd=9 result=42 -> cycle 2 writes r5=1 and md_ready=0; cycle 2 with no pipeline write -> cycle 3 writes r9=42 and md_ready=1. retire_count +2 total.
- Same-reg discard: addi r5 plus md_valid rd=5 -> only r5=mw_o written, buffer stays empty, md_ready stays 1, retire_count +1.
- MD exception and counting: div with md_ovf=1 -> r30=5; mul with md_ovf=1 -> r30=4. Preload retire_count to 2^CNT_W-1 via traffic (CNT_W=4, 15 retirements), then one more retirement -> wraps to 0.
